// File: rtl/rtc_timer_sequencer.sv
// Sequencer for the RTC hour/minute/second timer registers: arbitrates user
// write bursts against a periodic read sweep over a start/done register bus.
module rtc_timer_sequencer #(
  parameter int unsigned REFRESH_CYCLES = 1000000,
  parameter int unsigned TIMEOUT        = 4095
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr_req,
  input  logic [7:0] i_wr_hour,
  input  logic [7:0] i_wr_min,
  input  logic [7:0] i_wr_seg,
  output logic       o_wr_ack,
  output logic       o_bus_start,
  output logic       o_bus_rw,
  output logic [7:0] o_bus_addr,
  output logic [7:0] o_bus_wdata,
  input  logic [7:0] i_bus_rdata,
  input  logic       i_bus_done,
  output logic [7:0] o_en_sav_swr,
  output logic [7:0] o_en_rd,
  output logic [7:0] o_data_rd,
  output logic       o_sweep_done,
  output logic       o_err
);

  localparam int unsigned REF_W = $clog2(REFRESH_CYCLES);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  ADDR_HOUR = 8'h43;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t           r_state;
  logic             r_mode_wr;
  logic [1:0]       r_idx;
  logic             r_wr_pend;
  logic             r_rd_pend;
  logic [7:0]       r_sh_hour;
  logic [7:0]       r_sh_min;
  logic [7:0]       r_sh_seg;
  logic [7:0]       r_act_min;
  logic [7:0]       r_act_seg;
  logic [REF_W-1:0] r_ref_cnt;
  logic [TO_W-1:0]  r_wait_cnt;

  logic             r_bus_start;
  logic [7:0]       r_bus_addr;
  logic [7:0]       r_bus_wdata;
  logic             r_wr_ack;
  logic [7:0]       r_en_sav_swr;
  logic [7:0]       r_en_rd;
  logic [7:0]       r_data_rd;
  logic             r_sweep_done;
  logic             r_err;

  logic             w_tick;
  logic             w_wr_any;
  logic             w_rd_any;
  logic             w_acc_wr;
  logic             w_acc_rd;
  logic [1:0]       w_idx_nxt;
  logic [7:0]       w_addr_nxt;
  logic [7:0]       w_wdata_nxt;
  logic             w_timeout;

  // A request arriving in the IDLE cycle itself is accepted without first pending
  assign w_tick     = (r_ref_cnt == REF_W'(REFRESH_CYCLES - 1));
  assign w_wr_any   = r_wr_pend | i_wr_req;
  assign w_rd_any   = r_rd_pend | w_tick;
  assign w_acc_wr   = (r_state == S_IDLE) & w_wr_any;
  assign w_acc_rd   = (r_state == S_IDLE) & ~w_wr_any & w_rd_any;
  assign w_idx_nxt  = r_idx + 2'd1;
  assign w_addr_nxt = ADDR_HOUR - {6'd0, w_idx_nxt};
  assign w_timeout  = (r_wait_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    w_wdata_nxt = 8'h00;
    if (r_mode_wr) begin
      case (w_idx_nxt)
        2'd1:    w_wdata_nxt = r_act_min;
        2'd2:    w_wdata_nxt = r_act_seg;
        default: w_wdata_nxt = 8'h00;
      endcase
    end
  end

  // Free-running refresh counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ref_cnt <= '0;
    end else if (w_tick) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + REF_W'(1);
    end
  end

  // Pending flags and write shadow; active copy frozen for the running burst
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_pend <= 1'b0;
      r_rd_pend <= 1'b0;
      r_sh_hour <= 8'h00;
      r_sh_min  <= 8'h00;
      r_sh_seg  <= 8'h00;
      r_act_min <= 8'h00;
      r_act_seg <= 8'h00;
    end else begin
      r_wr_pend <= w_acc_wr ? 1'b0 : (r_wr_pend | i_wr_req);
      r_rd_pend <= w_acc_rd ? 1'b0 : (r_rd_pend | w_tick);
      if (i_wr_req) begin
        r_sh_hour <= i_wr_hour;
        r_sh_min  <= i_wr_min;
        r_sh_seg  <= i_wr_seg;
      end
      if (w_acc_wr) begin
        r_act_min <= i_wr_req ? i_wr_min : r_sh_min;
        r_act_seg <= i_wr_req ? i_wr_seg : r_sh_seg;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_mode_wr    <= 1'b0;
      r_idx        <= 2'd0;
      r_wait_cnt   <= '0;
      r_bus_start  <= 1'b0;
      r_bus_addr   <= 8'h00;
      r_bus_wdata  <= 8'h00;
      r_wr_ack     <= 1'b0;
      r_en_sav_swr <= 8'h00;
      r_en_rd      <= 8'h00;
      r_data_rd    <= 8'h00;
      r_sweep_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_bus_start  <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_en_sav_swr <= 8'h00;
      r_en_rd      <= 8'h00;
      r_sweep_done <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_wr_any) begin
            r_state     <= S_ISSUE;
            r_mode_wr   <= 1'b1;
            r_idx       <= 2'd0;
            r_bus_start <= 1'b1;
            r_bus_addr  <= ADDR_HOUR;
            r_bus_wdata <= i_wr_req ? i_wr_hour : r_sh_hour;
          end else if (w_rd_any) begin
            r_state     <= S_ISSUE;
            r_mode_wr   <= 1'b0;
            r_idx       <= 2'd0;
            r_bus_start <= 1'b1;
            r_bus_addr  <= ADDR_HOUR;
            r_bus_wdata <= 8'h00;
          end
        end
        S_ISSUE: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= '0;
        end
        S_WAIT: begin
          if (i_bus_done) begin
            if (r_mode_wr) begin
              r_en_sav_swr <= r_bus_addr;
            end else begin
              r_en_rd   <= r_bus_addr;
              r_data_rd <= i_bus_rdata;
            end
            if (r_idx == 2'd2) begin
              r_state      <= S_IDLE;
              r_wr_ack     <= r_mode_wr;
              r_sweep_done <= ~r_mode_wr;
            end else begin
              r_state     <= S_ISSUE;
              r_idx       <= w_idx_nxt;
              r_bus_start <= 1'b1;
              r_bus_addr  <= w_addr_nxt;
              r_bus_wdata <= w_wdata_nxt;
            end
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + TO_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_bus_start  = r_bus_start;
  assign o_bus_rw     = r_mode_wr;
  assign o_bus_addr   = r_bus_addr;
  assign o_bus_wdata  = r_bus_wdata;
  assign o_wr_ack     = r_wr_ack;
  assign o_en_sav_swr = r_en_sav_swr;
  assign o_en_rd      = r_en_rd;
  assign o_data_rd    = r_data_rd;
  assign o_sweep_done = r_sweep_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_rtc_timer_sequencer.sv
// Scoreboard bench for rtc_timer_sequencer: stimulus queues expected output
// events (kind, value, cycle); a negedge monitor pops and compares them.
module tb_rtc_timer_sequencer;

  localparam int unsigned REFRESH = 16;
  localparam int unsigned TMO     = 8;

  localparam int K_START = 0;
  localparam int K_ENWR  = 1;
  localparam int K_ENRD  = 2;
  localparam int K_ACK   = 3;
  localparam int K_SWEEP = 4;
  localparam int K_ERR   = 5;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_wr_req = 1'b0;
  logic [7:0] i_wr_hour = 8'h00;
  logic [7:0] i_wr_min = 8'h00;
  logic [7:0] i_wr_seg = 8'h00;
  logic [7:0] i_bus_rdata = 8'h00;
  logic       i_bus_done = 1'b0;
  logic       o_wr_ack;
  logic       o_bus_start;
  logic       o_bus_rw;
  logic [7:0] o_bus_addr;
  logic [7:0] o_bus_wdata;
  logic [7:0] o_en_sav_swr;
  logic [7:0] o_en_rd;
  logic [7:0] o_data_rd;
  logic       o_sweep_done;
  logic       o_err;

  rtc_timer_sequencer #(
    .REFRESH_CYCLES(REFRESH),
    .TIMEOUT       (TMO)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_wr_req    (i_wr_req),
    .i_wr_hour   (i_wr_hour),
    .i_wr_min    (i_wr_min),
    .i_wr_seg    (i_wr_seg),
    .o_wr_ack    (o_wr_ack),
    .o_bus_start (o_bus_start),
    .o_bus_rw    (o_bus_rw),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wdata (o_bus_wdata),
    .i_bus_rdata (i_bus_rdata),
    .i_bus_done  (i_bus_done),
    .o_en_sav_swr(o_en_sav_swr),
    .o_en_rd     (o_en_rd),
    .o_data_rd   (o_data_rd),
    .o_sweep_done(o_sweep_done),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus responder: done lat cycles after start; optional stall and early done
  int         b_lat = 3;
  bit         b_early = 1'b0;
  bit         b_stall = 1'b0;
  logic [7:0] b_stall_addr = 8'h42;
  logic [7:0] rd_h = 8'h01;
  logic [7:0] rd_m = 8'h02;
  logic [7:0] rd_s = 8'h03;
  bit         b_pend = 1'b0;
  int         b_cnt = 0;
  logic [7:0] b_addr = 8'h00;
  logic       b_rw = 1'b0;

  always @(negedge clk) begin
    i_bus_done = 1'b0;
    if (i_reset) begin
      b_pend = 1'b0;
    end else if (o_bus_start === 1'b1) begin
      b_pend = 1'b1;
      b_cnt  = 0;
      b_addr = o_bus_addr;
      b_rw   = o_bus_rw;
      if (b_early) begin
        i_bus_done  = 1'b1;
        i_bus_rdata = 8'hEE;
      end
    end else if (b_pend) begin
      b_cnt++;
      if (b_cnt == b_lat && !(b_stall && b_rw && b_addr == b_stall_addr)) begin
        i_bus_done  = 1'b1;
        i_bus_rdata = (b_addr == 8'h43) ? rd_h : (b_addr == 8'h42) ? rd_m : rd_s;
        b_pend      = 1'b0;
      end
    end
  end

  function automatic string kname(input int k);
    case (k)
      K_START: return "bus_start";
      K_ENWR:  return "en_sav_swr";
      K_ENRD:  return "en_rd";
      K_ACK:   return "wr_ack";
      K_SWEEP: return "sweep_done";
      default: return "err";
    endcase
  endfunction

  task automatic check_ev(input int kind, input logic [31:0] val);
    exp_t e;
    n_checks++;
    if (q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_%s: got val=%h at cycle %0d, required no event", kname(kind), val, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
        n_errors++;
        $display("FAIL %s: got %s val=%h cycle %0d, required %s val=%h cycle %0d",
                 kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_bus_start)         check_ev(K_START, {15'd0, o_bus_rw, o_bus_addr, o_bus_wdata});
      if (o_en_sav_swr != 0)   check_ev(K_ENWR, {24'd0, o_en_sav_swr});
      if (o_en_rd != 0)        check_ev(K_ENRD, {16'd0, o_en_rd, o_data_rd});
      if (o_wr_ack)            check_ev(K_ACK, 32'd0);
      if (o_sweep_done)        check_ev(K_SWEEP, 32'd0);
      if (o_err)               check_ev(K_ERR, 32'd0);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic exp_push(input int kind, input logic [31:0] val, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    q.push_back(e);
  endtask

  // Three-transaction burst starting at cycle s with bus latency lat
  task automatic exp_burst(input bit wr, input int s, input int lat,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] addr [3];
    logic [7:0] dat [3];
    int p;
    p = lat + 1;
    addr[0] = 8'h43; addr[1] = 8'h42; addr[2] = 8'h41;
    dat[0] = d0; dat[1] = d1; dat[2] = d2;
    for (int i = 0; i < 3; i++) begin
      exp_push(K_START, {15'd0, wr, addr[i], wr ? dat[i] : 8'h00}, s + i * p);
      if (i > 0)
        exp_push(wr ? K_ENWR : K_ENRD,
                 wr ? {24'd0, addr[i-1]} : {16'd0, addr[i-1], dat[i-1]}, s + i * p);
    end
    exp_push(wr ? K_ENWR : K_ENRD, wr ? {24'd0, addr[2]} : {16'd0, addr[2], dat[2]}, s + 3 * p);
    exp_push(wr ? K_ACK : K_SWEEP, 32'd0, s + 3 * p);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wr_pulse(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    i_wr_req = 1'b1; i_wr_hour = h; i_wr_min = m; i_wr_seg = s;
    @(negedge clk);
    i_wr_req = 1'b0; i_wr_hour = 8'hFF; i_wr_min = 8'hFF; i_wr_seg = 8'hFF;
  endtask

  task automatic end_test(input string name);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_missing: %0d events not seen, first %s due cycle %0d, required 0 left",
               name, q.size(), kname(q[0].kind), q[0].cyc);
      q.delete();
    end
  endtask

  // Reset for two cycles; all outputs must read 0 in the cycle after assertion
  task automatic do_reset(output int r0);
    i_reset = 1'b1;
    i_wr_req = 1'b0;
    @(negedge clk);
    chk("rst_bus_start", {31'd0, o_bus_start}, 32'd0);
    chk("rst_bus_rw", {31'd0, o_bus_rw}, 32'd0);
    chk("rst_bus_addr", {24'd0, o_bus_addr}, 32'd0);
    chk("rst_bus_wdata", {24'd0, o_bus_wdata}, 32'd0);
    chk("rst_wr_ack", {31'd0, o_wr_ack}, 32'd0);
    chk("rst_en_sav_swr", {24'd0, o_en_sav_swr}, 32'd0);
    chk("rst_en_rd", {24'd0, o_en_rd}, 32'd0);
    chk("rst_data_rd", {24'd0, o_data_rd}, 32'd0);
    chk("rst_sweep_done", {31'd0, o_sweep_done}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    @(negedge clk);
    i_reset = 1'b0;
    r0 = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    @(negedge clk);
    do_reset(r0);
    mon_en = 1'b1;

    // Basic write, latency 3
    b_lat = 3;
    wait_until(r0 + 1);
    exp_burst(1'b1, r0 + 2, 3, 8'h12, 8'h34, 8'h56);
    wr_pulse(8'h12, 8'h34, 8'h56);
    wait_until(r0 + 14);
    end_test("basic_write");
    do_reset(r0);

    // Read sweeps at minimum latency, repeating every REFRESH cycles
    b_lat = 1;
    rd_h = 8'h01; rd_m = 8'h02; rd_s = 8'h03;
    exp_burst(1'b0, r0 + 16, 1, 8'h01, 8'h02, 8'h03);
    wait_until(r0 + 25);
    chk("data_rd_hold", {24'd0, o_data_rd}, 32'h03);
    rd_h = 8'h0A; rd_m = 8'h0B; rd_s = 8'h0C;
    exp_burst(1'b0, r0 + 32, 1, 8'h0A, 8'h0B, 8'h0C);
    wait_until(r0 + 38);
    end_test("read_sweep");
    do_reset(r0);

    // Write request in the same cycle as the refresh tick
    b_lat = 3;
    rd_h = 8'h01; rd_m = 8'h02; rd_s = 8'h03;
    wait_until(r0 + 15);
    exp_burst(1'b1, r0 + 16, 3, 8'hA1, 8'hA2, 8'hA3);
    exp_burst(1'b0, r0 + 29, 3, 8'h01, 8'h02, 8'h03);
    wr_pulse(8'hA1, 8'hA2, 8'hA3);
    wait_until(r0 + 41);
    end_test("arb_same_cycle");
    do_reset(r0);

    // Write requests during a sweep; the second overwrites the shadow values
    exp_burst(1'b0, r0 + 16, 3, 8'h01, 8'h02, 8'h03);
    wait_until(r0 + 20);
    wr_pulse(8'hC1, 8'hC2, 8'hC3);
    wait_until(r0 + 22);
    wr_pulse(8'hD1, 8'hD2, 8'hD3);
    exp_burst(1'b1, r0 + 29, 3, 8'hD1, 8'hD2, 8'hD3);
    wait_until(r0 + 41);
    end_test("arb_during_sweep");
    do_reset(r0);

    // Timeout on the 0x42 write, then the next sweep runs normally
    b_stall = 1'b1;
    wait_until(r0 + 1);
    exp_push(K_START, {15'd0, 1'b1, 8'h43, 8'h11}, r0 + 2);
    exp_push(K_START, {15'd0, 1'b1, 8'h42, 8'h22}, r0 + 6);
    exp_push(K_ENWR, 32'h43, r0 + 6);
    exp_push(K_ERR, 32'd0, r0 + 15);
    exp_burst(1'b0, r0 + 16, 3, 8'h01, 8'h02, 8'h03);
    wr_pulse(8'h11, 8'h22, 8'h33);
    wait_until(r0 + 28);
    end_test("timeout");
    b_stall = 1'b0;
    do_reset(r0);

    // Reset while waiting on 0x42; no start until the next refresh tick
    wait_until(r0 + 1);
    exp_push(K_START, {15'd0, 1'b1, 8'h43, 8'h21}, r0 + 2);
    exp_push(K_START, {15'd0, 1'b1, 8'h42, 8'h22}, r0 + 6);
    exp_push(K_ENWR, 32'h43, r0 + 6);
    wr_pulse(8'h21, 8'h22, 8'h23);
    wait_until(r0 + 8);
    end_test("pre_reset_burst");
    do_reset(r0);
    exp_push(K_START, {15'd0, 1'b0, 8'h43, 8'h00}, r0 + 16);
    wait_until(r0 + 16);
    end_test("reset_mid_burst");
    do_reset(r0);

    // Done during ISSUE is ignored; the later done completes each transaction
    b_lat = 2;
    b_early = 1'b1;
    wait_until(r0 + 1);
    exp_burst(1'b1, r0 + 2, 2, 8'h5A, 8'h5B, 8'h5C);
    wr_pulse(8'h5A, 8'h5B, 8'h5C);
    wait_until(r0 + 11);
    end_test("early_done");
    b_early = 1'b0;
    do_reset(r0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rtc_timer_sequencer.md
# rtc_timer_sequencer

Scheduler that owns the RTC timer register bus and sequences all accesses to the hour/minute/second timer registers (addresses 0x43/0x42/0x41). It arbitrates between user write requests and a periodic read sweep, runs each as a three-transaction burst over a start/done bus handshake, and generates the one-cycle address strobes (`en_sav_swr`, `en_rd`) and `data_rd` consumed by the alarm comparison and VGA display logic.

## Interface
- `REFRESH_CYCLES`, default 1000000: clock cycles between read-sweep requests; must be ≥ 2.
- `TIMEOUT`, default 4095: maximum wait for `bus_done` per transaction; must be ≥ 1.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `wr_req` in 1: one-cycle pulse requesting a write of the three timer values.
- `wr_hour`, `wr_min`, `wr_seg` in 8 each: timer values, sampled only in the cycle `wr_req` is high.
- `wr_ack` out 1: one-cycle pulse when all three writes have completed.
- `bus_start` out 1: one-cycle transaction launch.
- `bus_rw` out 1: 1 = write, 0 = read.
- `bus_addr` out 8: register address, 0x43/0x42/0x41.
- `bus_wdata` out 8: write data.
- `bus_rdata` in 8: read data, valid in the cycle `bus_done` is high.
- `bus_done` in 1: transaction complete.
- `en_sav_swr` out 8: address code pulsed for one cycle per completed write, else 0x00.
- `en_rd` out 8: address code pulsed for one cycle per completed read, else 0x00.
- `data_rd` out 8: last read value; updates together with `en_rd` and holds afterwards.
- `sweep_done` out 1: one-cycle pulse when a read sweep completes.
- `err` out 1: one-cycle pulse on a transaction timeout.

## Operation
- FSM states: IDLE, ISSUE, WAIT. A mode register (WR/RD) and a 2-bit index select the address.
- Address order is always 0x43 → 0x42 → 0x41 (hour, minute, second) for both writes and reads.
- `wr_req` sets `wr_pend` and latches the three values into shadow registers.
  - A `wr_req` while `wr_pend` is already set overwrites the shadow values; only one write burst runs.
- The refresh counter is free-running, counts 0..REFRESH_CYCLES−1 and wraps.
  - At terminal count it sets `rd_pend`. Multiple ticks while pending collapse into one sweep.
- In IDLE, `wr_pend` takes priority over `rd_pend`. Accepting a burst clears its pend flag and loads index 0.
- A burst in progress is never preempted. A write request during a sweep waits for the sweep to finish.
- ISSUE:
  - `bus_start`=1 for exactly one cycle.
  - `bus_addr`, `bus_rw` and `bus_wdata` are driven in this cycle and held stable until done or timeout.
  - `bus_wdata`=0x00 for reads.
- WAIT:
  - `bus_done` is sampled only in WAIT; a `bus_done` asserted during ISSUE is ignored.
  - On `bus_done`, the next cycle pulses the address code on `en_sav_swr` (write) or `en_rd` (read, with `data_rd` = the `bus_rdata` captured on done).
  - The index then advances to the next address and the FSM returns to ISSUE; after the 0x41 transaction it returns to IDLE.
- Last write done: `wr_ack` pulses together with `en_sav_swr`=0x41. Last read done: `sweep_done` pulses with `en_rd`=0x41.
- Timeout:
  - The wait counter clears on entry to WAIT.
  - If it reaches TIMEOUT with no `bus_done`: `err` pulses, the burst is abandoned and the FSM returns to IDLE.
  - No `en_*` pulse for the failed address, no `wr_ack`/`sweep_done`. The dropped request is not retried.
- Reset values:
  - All outputs 0.
  - State IDLE; pend flags, shadow registers and counters 0.
  - Reset mid-burst abandons the burst silently; no further `bus_start` until a new request.

## Timing
- `wr_req` high in cycle t while IDLE with no read pending: cycle t+1 ISSUE, `bus_start`=1, `bus_addr`=0x43, `bus_rw`=1.
- `bus_done` in WAIT at cycle d:
  - cycle d+1 carries the `en_*` pulse and the next ISSUE (`bus_start`=1) simultaneously.
  - Minimum transaction is 2 cycles; minimum burst is 6 cycles.
- If the refresh tick and `wr_req` occur in the same cycle, the write burst runs first and the sweep starts the cycle after the last write ends (IDLE for one cycle).
- The first refresh tick occurs REFRESH_CYCLES cycles after `reset` deasserts.

## Test plan
- **Basic write.** Reset, then `wr_req` with 0x12/0x34/0x56; bus responds `bus_done` 3 cycles after each start. Required:
  - three starts, addr 0x43/0x42/0x41, wdata 0x12/0x34/0x56;
  - `en_sav_swr` pulses 0x43, 0x42, 0x41;
  - `wr_ack` coincides with 0x41.
- **Read sweep.** REFRESH_CYCLES=16; bus returns 0x01/0x02/0x03. Required:
  - reads start at cycle 17 after reset;
  - `en_rd` pulses 0x43/0x42/0x41 with `data_rd` 0x01/0x02/0x03;
  - `sweep_done` with the last pulse;
  - this repeats every 16 cycles.
- **Arbitration.**
  - `wr_req` in the same cycle as the refresh tick → the write burst completes first, then the read sweep.
  - `wr_req` during a sweep → the sweep finishes uninterrupted, then the write burst runs.
- **Timeout.** TIMEOUT=8; the bus never asserts done on 0x42 during a write. Required:
  - `err` pulses 8 cycles into WAIT;
  - `en_sav_swr`=0x43 only; no `wr_ack`;
  - the FSM returns to IDLE and the next sweep proceeds normally.
- **Reset mid-burst.** Assert `reset` while in WAIT on 0x42. Required: all outputs 0 the next cycle, and no `bus_start` until the next `wr_req` or refresh tick.
- **Early done ignored.** `bus_done` asserted in the ISSUE cycle, then again 2 cycles later. Only the second completes the transaction, giving a single `en_*` pulse.
